// File: rtl/axi_slave_rd_arbiter_if.sv
// Read-channel (AR/R) bundle between NM masters, the read arbiter and one axi_slave.
// Modport slave is the arbiter's view; modport master is the surrounding masters + slave model.
interface axi_slave_rd_arbiter_if #(
    parameter int NM           = 2,
    parameter int AXI_ID_WIDTH = 4
);
    // master side, master k owns slice [k*W +: W]
    logic [NM-1:0]              i_m_arvalid;
    logic [NM*32-1:0]           i_m_araddr;
    logic [NM*AXI_ID_WIDTH-1:0] i_m_arid;
    logic [NM*4-1:0]            i_m_arlen;
    logic [NM-1:0]              o_m_arready;
    logic [NM*32-1:0]           o_m_rdata;
    logic [NM*AXI_ID_WIDTH-1:0] o_m_rid;
    logic [NM*2-1:0]            o_m_rresp;
    logic [NM-1:0]              o_m_rlast;
    logic [NM-1:0]              o_m_rvalid;
    logic [NM-1:0]              i_m_rready;

    // slave side
    logic [31:0]                o_araddr;
    logic [AXI_ID_WIDTH-1:0]    o_arid;
    logic [3:0]                 o_arlen;
    logic                       o_arvalid;
    logic                       i_arready;
    logic [31:0]                i_rdata;
    logic [AXI_ID_WIDTH-1:0]    i_rid;
    logic [1:0]                 i_rresp;
    logic                       i_rlast;
    logic                       i_rvalid;
    logic                       o_rready;

    modport slave (
        input  i_m_arvalid, i_m_araddr, i_m_arid, i_m_arlen, i_m_rready,
        input  i_arready, i_rdata, i_rid, i_rresp, i_rlast, i_rvalid,
        output o_m_arready, o_m_rdata, o_m_rid, o_m_rresp, o_m_rlast, o_m_rvalid,
        output o_araddr, o_arid, o_arlen, o_arvalid, o_rready
    );

    modport master (
        output i_m_arvalid, i_m_araddr, i_m_arid, i_m_arlen, i_m_rready,
        output i_arready, i_rdata, i_rid, i_rresp, i_rlast, i_rvalid,
        input  o_m_arready, o_m_rdata, o_m_rid, o_m_rresp, o_m_rlast, o_m_rvalid,
        input  o_araddr, o_arid, o_arlen, o_arvalid, o_rready
    );
endinterface

// File: rtl/axi_slave_rd_arbiter.sv
// Round-robin arbiter sharing one axi_slave read port among NM masters, one burst at a time.
// Grant is held from the AR handshake to the rlast beat; burst length is checked against rlast.
module axi_slave_rd_arbiter #(
    parameter int NM           = 2,
    parameter int AXI_ID_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_slave_rd_arbiter_if.slave bus,
    output logic [NM-1:0]        o_gnt,
    output logic                 o_len_err,
    output logic [1:0]           o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a source holds valid and payload stable until it sees ready, and ready never waits on valid.

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] gidx, gidx_nxt;
    logic [NM-1:0] gnt_nxt;
    logic [3:0]    cnt, cnt_nxt;

    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [2*NM-1:0] req_dbl;
    logic [2*NM-1:0] req_rot;
    int              pick_pos;

    assign o_dbg_state = state;

    // Rotate requests so bit 0 is the master at ptr; first set bit wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        pick_pos = 0;
        req_dbl  = {bus.i_m_arvalid, bus.i_m_arvalid};
        req_rot  = req_dbl >> ptr;
        for (int i = 0; i < NM; i++) begin
            if (!pick_vld && req_rot[i]) begin
                pick_vld = 1'b1;
                pick_pos = int'(ptr) + i;
                if (pick_pos >= NM) begin
                    pick_pos = pick_pos - NM;
                end
                pick = IW'(pick_pos);
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        gidx_nxt        = gidx;
        gnt_nxt         = o_gnt;
        cnt_nxt         = cnt;
        o_len_err       = 1'b0;
        bus.o_arvalid   = 1'b0;
        bus.o_araddr    = '0;
        bus.o_arid      = '0;
        bus.o_arlen     = '0;
        bus.o_rready    = 1'b0;
        bus.o_m_arready = '0;
        bus.o_m_rdata   = '0;
        bus.o_m_rid     = '0;
        bus.o_m_rresp   = '0;
        bus.o_m_rlast   = '0;
        bus.o_m_rvalid  = '0;

        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gidx_nxt = pick;
                    for (int k = 0; k < NM; k++) begin
                        gnt_nxt[k] = (pick == IW'(k));
                    end
                    state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                for (int k = 0; k < NM; k++) begin
                    if (gidx == IW'(k)) begin
                        bus.o_arvalid      = bus.i_m_arvalid[k];
                        bus.o_araddr       = bus.i_m_araddr[k*32 +: 32];
                        bus.o_arid         = bus.i_m_arid[k*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                        bus.o_arlen        = bus.i_m_arlen[k*4 +: 4];
                        bus.o_m_arready[k] = bus.i_arready;
                    end
                end
                if (bus.o_arvalid && bus.i_arready) begin
                    cnt_nxt   = bus.o_arlen;
                    state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                for (int k = 0; k < NM; k++) begin
                    if (gidx == IW'(k)) begin
                        bus.o_m_rvalid[k]                             = bus.i_rvalid;
                        bus.o_m_rdata[k*32 +: 32]                     = bus.i_rdata;
                        bus.o_m_rid[k*AXI_ID_WIDTH +: AXI_ID_WIDTH]   = bus.i_rid;
                        bus.o_m_rresp[k*2 +: 2]                       = bus.i_rresp;
                        bus.o_m_rlast[k]                              = bus.i_rlast;
                        bus.o_rready                                  = bus.i_m_rready[k];
                    end
                end
                if (bus.i_rvalid && bus.o_rready) begin
                    // The slave's rlast ends the burst even when it disagrees with arlen.
                    o_len_err = (bus.i_rlast && (cnt != 4'd0)) ||
                                (!bus.i_rlast && (cnt == 4'd0));
                    if (bus.i_rlast) begin
                        gnt_nxt   = '0;
                        ptr_nxt   = (gidx == IW'(NM - 1)) ? '0 : gidx + IW'(1);
                        state_nxt = ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end

            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            ptr   <= '0;
            gidx  <= '0;
            o_gnt <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gidx  <= gidx_nxt;
            o_gnt <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_axi_slave_rd_arbiter.sv
// Bench for axi_slave_rd_arbiter: per-cycle vector table, then a stalled 4-beat burst
// with a data scoreboard and a reset-mid-burst sequence.
module tb_axi_slave_rd_arbiter;
    logic       clk;
    logic       rstn;
    logic [1:0] gnt;
    logic       len_err;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    axi_slave_rd_arbiter_if #(.NM(2), .AXI_ID_WIDTH(4)) bus ();

    axi_slave_rd_arbiter #(.NM(2), .AXI_ID_WIDTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_gnt       (gnt),
        .o_len_err   (len_err),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [1:0] mv;
        logic [3:0] len0;
        logic [3:0] len1;
        logic       ard;
        logic       rv;
        logic       rl;
        logic [1:0] mrr;
        logic [1:0] e_gnt;
        logic       e_arv;
        logic [3:0] e_arlen;
        logic [1:0] e_marr;
        logic [1:0] e_mrv;
        logic       e_rr;
        logic       e_err;
    } vec_t;

    vec_t vt[35];
    logic [31:0] exp_q[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] mv,
                                input logic [3:0] l0, input logic [3:0] l1,
                                input logic ard, input logic rv, input logic rl,
                                input logic [1:0] mrr, input logic [1:0] eg,
                                input logic ea, input logic [3:0] el,
                                input logic [1:0] emar, input logic [1:0] emrv,
                                input logic err, input logic eerr);
        vec_t v;
        v.rst = rst; v.mv = mv; v.len0 = l0; v.len1 = l1;
        v.ard = ard; v.rv = rv; v.rl = rl; v.mrr = mrr;
        v.e_gnt = eg; v.e_arv = ea; v.e_arlen = el; v.e_marr = emar;
        v.e_mrv = emrv; v.e_rr = err; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_m_arvalid = '0;
        bus.i_m_araddr  = {32'h0000_0200, 32'h0000_0100};
        bus.i_m_arid    = {4'h5, 4'h3};
        bus.i_m_arlen   = '0;
        bus.i_m_rready  = '0;
        bus.i_arready   = 1'b0;
        bus.i_rdata     = '0;
        bus.i_rid       = '0;
        bus.i_rresp     = '0;
        bus.i_rlast     = 1'b0;
        bus.i_rvalid    = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        rstn            = v.rst;
        bus.i_m_arvalid = v.mv;
        bus.i_m_arlen   = {v.len1, v.len0};
        bus.i_arready   = v.ard;
        bus.i_rvalid    = v.rv;
        bus.i_rlast     = v.rl;
        bus.i_rdata     = 32'hCAFE_0000 | 32'(idx);
        bus.i_m_rready  = v.mrr;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_d;
        int          beat;
        int          got;
        int          err_seen;
        logic        rv;
        logic        rr1;

        rstn = 1'b0;
        drive_idle();

        // rst mv  l0 l1 ard rv rl mrr  | gnt arv arlen marr mrv rr err
        vt[0]  = mk(1, 2'b01, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[1]  = mk(1, 2'b01, 0, 0, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
        vt[2]  = mk(1, 2'b00, 0, 0, 0, 1, 1, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[3]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[4]  = mk(0, 2'b11, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[5]  = mk(1, 2'b11, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[6]  = mk(1, 2'b11, 0, 0, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
        vt[7]  = mk(1, 2'b10, 0, 0, 0, 1, 1, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[8]  = mk(1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[9]  = mk(1, 2'b11, 0, 0, 1, 0, 0, 2'b00, 2'b10, 1, 0, 2'b10, 2'b00, 0, 0);
        vt[10] = mk(1, 2'b01, 0, 0, 0, 1, 1, 2'b11, 2'b10, 0, 0, 2'b00, 2'b10, 1, 0);
        vt[11] = mk(1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[12] = mk(1, 2'b11, 0, 0, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
        vt[13] = mk(1, 2'b10, 0, 0, 0, 1, 1, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[14] = mk(1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[15] = mk(1, 2'b10, 0, 0, 1, 0, 0, 2'b00, 2'b10, 1, 0, 2'b10, 2'b00, 0, 0);
        vt[16] = mk(1, 2'b00, 0, 0, 0, 1, 1, 2'b11, 2'b10, 0, 0, 2'b00, 2'b10, 1, 0);
        vt[17] = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[18] = mk(1, 2'b01, 2, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[19] = mk(1, 2'b11, 2, 1, 0, 0, 0, 2'b00, 2'b01, 1, 2, 2'b00, 2'b00, 0, 0);
        vt[20] = mk(1, 2'b11, 2, 1, 1, 0, 0, 2'b00, 2'b01, 1, 2, 2'b01, 2'b00, 0, 0);
        vt[21] = mk(1, 2'b10, 2, 1, 0, 1, 0, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[22] = mk(1, 2'b10, 2, 1, 0, 0, 0, 2'b11, 2'b01, 0, 0, 2'b00, 2'b00, 1, 0);
        vt[23] = mk(1, 2'b10, 2, 1, 0, 1, 0, 2'b10, 2'b01, 0, 0, 2'b00, 2'b01, 0, 0);
        vt[24] = mk(1, 2'b10, 2, 1, 0, 1, 0, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[25] = mk(1, 2'b10, 2, 1, 0, 1, 1, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[26] = mk(1, 2'b10, 2, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[27] = mk(1, 2'b10, 2, 1, 1, 0, 0, 2'b00, 2'b10, 1, 1, 2'b10, 2'b00, 0, 0);
        vt[28] = mk(1, 2'b00, 2, 1, 0, 1, 1, 2'b11, 2'b10, 0, 0, 2'b00, 2'b10, 1, 1);
        vt[29] = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[30] = mk(1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        vt[31] = mk(1, 2'b01, 0, 0, 1, 0, 0, 2'b00, 2'b01, 1, 0, 2'b01, 2'b00, 0, 0);
        vt[32] = mk(1, 2'b00, 0, 0, 0, 1, 0, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 1);
        vt[33] = mk(1, 2'b00, 0, 0, 0, 1, 1, 2'b11, 2'b01, 0, 0, 2'b00, 2'b01, 1, 0);
        vt[34] = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);

        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 35; i++) begin
            apply_vec(vt[i], i);
            #4;
            exp_addr = !vt[i].e_arv ? 32'h0 : (vt[i].e_gnt == 2'b10 ? 32'h200 : 32'h100);
            chk($sformatf("v%0d_gnt", i),      64'(gnt),             64'(vt[i].e_gnt));
            chk($sformatf("v%0d_arvalid", i),  64'(bus.o_arvalid),   64'(vt[i].e_arv));
            chk($sformatf("v%0d_arlen", i),    64'(bus.o_arlen),     64'(vt[i].e_arlen));
            chk($sformatf("v%0d_araddr", i),   64'(bus.o_araddr),    64'(exp_addr));
            chk($sformatf("v%0d_m_arready", i), 64'(bus.o_m_arready), 64'(vt[i].e_marr));
            chk($sformatf("v%0d_m_rvalid", i), 64'(bus.o_m_rvalid),  64'(vt[i].e_mrv));
            chk($sformatf("v%0d_rready", i),   64'(bus.o_rready),    64'(vt[i].e_rr));
            chk($sformatf("v%0d_len_err", i),  64'(len_err),         64'(vt[i].e_err));
            step();
        end

        // m1 len=3 burst with slave and master stalls; arbitration pointer now sits on m1
        drive_idle();
        for (int b = 0; b < 4; b++) exp_q.push_back(32'hA0 + 32'(b));
        bus.i_m_arvalid = 2'b10;
        bus.i_m_arlen   = {4'd3, 4'd0};
        bus.i_arready   = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (bus.o_m_arready[1] && bus.o_arvalid) begin
                chk("burst_araddr", 64'(bus.o_araddr), 64'h200);
                chk("burst_arid",   64'(bus.o_arid),   64'h5);
                chk("burst_arlen",  64'(bus.o_arlen),  64'h3);
                got = 1;
            end
            step();
            if (got != 0) break;
        end
        chk("burst_ar_handshake", 64'(got), 64'd1);
        bus.i_m_arvalid = 2'b00;
        bus.i_rid       = 4'h5;
        beat     = 0;
        err_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (beat == 4) break;
            rv  = (c % 3) != 1;
            rr1 = (c % 4) != 2;
            bus.i_rvalid   = rv;
            bus.i_rlast    = (beat == 3);
            bus.i_rdata    = 32'hA0 + 32'(beat);
            bus.i_m_rready = {rr1, 1'b1};
            #4;
            chk("burst_m1_rvalid", 64'(bus.o_m_rvalid[1]), 64'(rv));
            chk("burst_m0_rvalid", 64'(bus.o_m_rvalid[0]), 64'd0);
            chk("burst_rready",    64'(bus.o_rready),      64'(rr1));
            if (rv && rr1) begin
                exp_d = exp_q.pop_front();
                chk("burst_rdata", 64'(bus.o_m_rdata[63:32]), 64'(exp_d));
                chk("burst_rid",   64'(bus.o_m_rid[7:4]),     64'h5);
                chk("burst_rlast", 64'(bus.o_m_rlast[1]),     64'(beat == 3));
                beat++;
            end
            if (len_err) err_seen++;
            step();
        end
        chk("burst_beats", 64'(beat), 64'd4);
        chk("burst_q_empty", 64'(exp_q.size()), 64'd0);
        chk("burst_no_len_err", 64'(err_seen), 64'd0);
        bus.i_rvalid = 1'b0;
        bus.i_rlast  = 1'b0;
        #4;
        chk("burst_gnt_released", 64'(gnt), 64'd0);
        step();

        // m0 single beat to move the pointer to m1, then reset in the middle of an m1 burst
        bus.i_m_arvalid = 2'b01;
        bus.i_arready   = 1'b1;
        step();
        step();
        bus.i_m_arvalid = 2'b00;
        bus.i_rvalid    = 1'b1;
        bus.i_rlast     = 1'b1;
        bus.i_m_rready  = 2'b11;
        step();
        bus.i_rvalid    = 1'b0;
        bus.i_rlast     = 1'b0;
        bus.i_m_arvalid = 2'b10;
        step();
        step();
        bus.i_m_arvalid = 2'b00;
        bus.i_rvalid    = 1'b1;
        #2;
        chk("rst_pre_m_rvalid", 64'(bus.o_m_rvalid), 64'b10);
        rstn = 1'b0;
        #1;
        chk("rst_gnt",       64'(gnt),             64'd0);
        chk("rst_m_rvalid",  64'(bus.o_m_rvalid),  64'd0);
        chk("rst_rready",    64'(bus.o_rready),    64'd0);
        chk("rst_arvalid",   64'(bus.o_arvalid),   64'd0);
        chk("rst_m_arready", 64'(bus.o_m_arready), 64'd0);
        chk("rst_state",     64'(dbg_state),       64'd0);
        bus.i_rvalid = 1'b0;
        step();
        rstn            = 1'b1;
        bus.i_m_arvalid = 2'b11;
        #3;
        chk("rst_idle_gnt", 64'(gnt), 64'd0);
        step();
        #3;
        chk("rst_first_gnt",    64'(gnt),          64'b01);
        chk("rst_first_araddr", 64'(bus.o_araddr), 64'h100);
        drive_idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
